// File: rtl/tff_counter_ctrl.sv
// Sequencer for an external chain of T flip-flops: drives the per-stage toggle vector
// from the fed-back q to clear, count up/down with a prescaler, or run one-shot to a target.
//
// state | meaning
// ------+---------------------------------------------------------------
// CLEAR | toggle every set bit of q until the chain reads zero
// IDLE  | chain held; waiting for start or clear_req
// RUN   | prescaled counting using the dir/mode/target latched at start
// DONE  | one-shot target reached; single-cycle done pulse
module tff_counter_ctrl #(
  parameter int WIDTH    = 3,
  parameter int PRESCALE = 4
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             clear_req,
  input  logic             dir,
  input  logic             mode,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t,
  output logic             tick,
  output logic             busy,
  output logic             done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [PW-1:0]    pre;
  logic             dir_r;
  logic             mode_r;
  logic [WIDTH-1:0] target_r;
  logic [WIDTH-1:0] t_step;
  logic [WIDTH-1:0] q_step;
  logic             tick_int;
  logic             carry;
  logic             at_target;
  logic             start_ok;

  assign tick_int  = (state == S_RUN) && (pre == PS_LAST);
  assign at_target = (q == target_r);
  assign start_ok  = (state == S_IDLE) && !clear_req && start;

  // Stage i toggles when all lower stages are at the rollover value for the direction.
  always_comb begin
    t_step = '0;
    carry  = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      t_step[i] = carry;
      carry     = carry & (dir_r ? q[i] : ~q[i]);
    end
    q_step = q ^ t_step;
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state    <= S_CLEAR;
      pre      <= '0;
      dir_r    <= 1'b1;
      mode_r   <= 1'b0;
      target_r <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        pre      <= '0;
        dir_r    <= dir;
        mode_r   <= mode;
        target_r <= target;
      end else if (state == S_RUN) begin
        pre <= tick_int ? '0 : pre + 1'b1;
      end else begin
        pre <= '0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR: if (q == '0) state_nxt = S_IDLE;
      S_IDLE: begin
        if (clear_req)  state_nxt = S_CLEAR;
        else if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (clear_req)     state_nxt = S_CLEAR;
        else if (stop)     state_nxt = S_IDLE;
        else if (tick_int && mode_r && (at_target || (q_step == target_r)))
          state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_CLEAR;
    endcase
  end

  // A tick coinciding with stop/clear_req, or a one-shot already at target, takes no step.
  always_comb begin
    t    = '0;
    tick = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    if (!reset) begin
      case (state)
        S_CLEAR: begin
          t    = q;
          busy = 1'b1;
        end
        S_RUN: begin
          busy = 1'b1;
          tick = tick_int;
          if (tick_int && !clear_req && !stop && !(mode_r && at_target))
            t = t_step;
        end
        S_DONE:  done = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
